// File: rtl/neural_pkg.sv
// Shared types and default geometry for the neural blend datapath.
// The channel slice helper is sized for the default geometry.
package neural_pkg;

  localparam int NB_DATA_W = 8;
  localparam int NB_CH     = 3;
  localparam int NB_MASK_W = 8;
  localparam int NB_CNT_W  = 32;

  localparam int MAXM = (1 << NB_MASK_W) - 1;
  localparam int MAXD = (1 << NB_DATA_W) - 1;

  typedef enum logic [1:0] {
    MODE_BLEND   = 2'd0,
    MODE_PASS_T  = 2'd1,
    MODE_PASS_T1 = 2'd2,
    MODE_ABSDIFF = 2'd3
  } mode_e;

  function automatic logic [NB_DATA_W-1:0] ch_slice(
    input logic [NB_CH*NB_DATA_W-1:0] pix,
    input int                         c
  );
    return pix[c*NB_DATA_W +: NB_DATA_W];
  endfunction

endpackage

// File: rtl/neural_div_maxm.sv
// Combinational rounded divide by MAXM = 2^MASK_W-1 for one channel.
// Uses the add-back identity: q = (r + (r >> MASK_W)) >> MASK_W, r = s + half.
module neural_div_maxm
  import neural_pkg::*;
#(
  parameter int DATA_W = NB_DATA_W,
  parameter int MASK_W = NB_MASK_W
) (
  input  logic [DATA_W+MASK_W-1:0] s_i,
  output logic [DATA_W-1:0]        q_o
);

  localparam int SW = DATA_W + MASK_W;
  localparam logic [SW+1:0] HALF = {{(SW+1){1'b0}}, 1'b1} << (MASK_W - 1);

  logic [SW+1:0] r;
  logic [SW+1:0] acc;
  logic          unused_bits;

  // Two guard bits keep the rounding offset and add-back free of overflow.
  assign r   = {2'b00, s_i} + HALF;
  assign acc = r + (r >> MASK_W);
  assign q_o = acc[MASK_W +: DATA_W];

  assign unused_bits = ^{acc[MASK_W-1:0], acc[SW+1:SW]};

endmodule

// File: rtl/neural_blend_pipe.sv
// Two-stage streaming blend / pass-through / absolute-difference pipe.
// Stage 1 registers per-channel sums, stage 2 registers the divided result.
module neural_blend_pipe
  import neural_pkg::*;
#(
  parameter int DATA_W = NB_DATA_W,
  parameter int CH     = NB_CH,
  parameter int MASK_W = NB_MASK_W,
  parameter int CNT_W  = NB_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_pix_t,
  input  logic [CH*DATA_W-1:0] in_pix_t1,
  input  logic [MASK_W-1:0]    in_mask,
  input  logic [1:0]           in_mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_pix,
  output logic                 out_last,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int SW = DATA_W + MASK_W;
  localparam logic [MASK_W-1:0] MAXM_L = '1;

  // Handshake: a beat moves on a side when valid & ready are both high at a
  // clk edge; valid never waits on ready, and in_ready = en is combinational
  // on out_ready so the whole pipe advances or holds as one.
  logic en;

  logic [SW-1:0]       s1_d [CH];
  logic [SW-1:0]       s1_q [CH];
  mode_e               mode_in;
  mode_e               mode1_q;
  logic                last1_q;
  logic                v1_q;
  logic [MASK_W-1:0]   inv_mask;
  logic [CH*DATA_W-1:0] pix2_d;

  logic                 out_valid_q;
  logic [CH*DATA_W-1:0] out_pix_q;
  logic                 out_last_q;
  logic [CNT_W-1:0]     beat_cnt_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign mode_in  = mode_e'(in_mode);
  assign inv_mask = MAXM_L - in_mask;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DATA_W-1:0] t;
    logic [DATA_W-1:0] t1;
    logic [DATA_W-1:0] diff;
    logic [SW-1:0]     prod;
    logic [DATA_W-1:0] q;

    assign t    = in_pix_t[c*DATA_W +: DATA_W];
    assign t1   = in_pix_t1[c*DATA_W +: DATA_W];
    assign diff = (t >= t1) ? (t - t1) : (t1 - t);
    assign prod = SW'(t) * SW'(in_mask) + SW'(t1) * SW'(inv_mask);

    assign s1_d[c] = (mode_in == MODE_BLEND)   ? prod     :
                     (mode_in == MODE_PASS_T)  ? SW'(t)   :
                     (mode_in == MODE_PASS_T1) ? SW'(t1)  :
                                                 SW'(diff);

    neural_div_maxm #(.DATA_W(DATA_W), .MASK_W(MASK_W)) u_div (
      .s_i (s1_q[c]),
      .q_o (q)
    );

    // Non-blend modes already hold the final value in the low bits.
    assign pix2_d[c*DATA_W +: DATA_W] = (mode1_q == MODE_BLEND) ? q : s1_q[c][DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      mode1_q     <= MODE_BLEND;
      last1_q     <= 1'b0;
      for (int c = 0; c < CH; c++) s1_q[c] <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_last_q  <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      if (out_valid_q && out_ready) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      if (en) begin
        v1_q <= in_valid;
        if (in_valid) begin
          for (int c = 0; c < CH; c++) s1_q[c] <= s1_d[c];
          mode1_q <= mode_in;
          last1_q <= in_last;
        end
        out_valid_q <= v1_q;
        if (v1_q) begin
          out_pix_q  <= pix2_d;
          out_last_q <= last1_q;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_last  = out_last_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_neural_blend_pipe.sv
// Self-checking bench for neural_blend_pipe: directed steps, random traffic,
// and a behavioural rounding model driving an expected-beat queue.
module tb_neural_blend_pipe;
  import neural_pkg::*;

  localparam int DW = NB_DATA_W;
  localparam int CH = NB_CH;
  localparam int MW = NB_MASK_W;
  localparam int CW = NB_CNT_W;
  localparam int PW = CH * DW;

  // Clock / reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_pix_t = '0;
  logic [PW-1:0] in_pix_t1 = '0;
  logic [MW-1:0] in_mask = '0;
  logic [1:0]    in_mode = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] out_pix;
  logic          out_last;
  logic [CW-1:0] beat_cnt;

  always #5 clk = ~clk;

  neural_blend_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix_t  (in_pix_t),
    .in_pix_t1 (in_pix_t1),
    .in_mask   (in_mask),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_last  (out_last),
    .beat_cnt  (beat_cnt)
  );

  logic [DW+MW-1:0] div_s = '0;
  logic [DW-1:0]    div_q;

  neural_div_maxm #(.DATA_W(DW), .MASK_W(MW)) u_div_chk (
    .s_i (div_s),
    .q_o (div_q)
  );

  // Scoreboard state
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [PW:0] exp_q[$];
  int          hs_cnt = 0;
  int          stall_cycles = 0;
  logic        last_acc = 1'b0;

  function automatic logic [DW-1:0] ref_ch(input int t, input int t1, input int m, input logic [1:0] mode);
    int s;
    case (mode)
      MODE_BLEND: begin
        s = t * m + t1 * (MAXM - m);
        return DW'((2 * s + MAXM) / (2 * MAXM));
      end
      MODE_PASS_T:  return DW'(t);
      MODE_PASS_T1: return DW'(t1);
      default:      return (t > t1) ? DW'(t - t1) : DW'(t1 - t);
    endcase
  endfunction

  function automatic logic [PW-1:0] ref_pix(input logic [PW-1:0] t, input logic [PW-1:0] t1,
                                             input logic [MW-1:0] m, input logic [1:0] mode);
    logic [PW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      r[c*DW +: DW] = ref_ch(int'(ch_slice(t, c)), int'(ch_slice(t1, c)), int'(m), mode);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [PW-1:0] t, input logic [PW-1:0] t1,
                       input logic [MW-1:0] m, input logic [1:0] mode, input logic last);
    in_valid  = v;
    in_pix_t  = t;
    in_pix_t1 = t1;
    in_mask   = m;
    in_mode   = mode;
    in_last   = last;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, PW'({$urandom, $urandom}), PW'({$urandom, $urandom}), MW'($urandom),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endtask

  // One clock: sample handshakes between edges, score, then advance.
  task automatic cycle();
    logic        acc;
    logic        ohs;
    logic [PW:0] exp;
    #1;
    acc = in_valid && in_ready && rst_n;
    ohs = out_valid && out_ready && rst_n;
    if (out_valid && !out_ready && rst_n) begin
      stall_cycles++;
      check("stall_in_ready", in_ready, 0);
    end
    if (ohs) begin
      check("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("out_beat", {out_last, out_pix}, exp);
      end
      hs_cnt++;
    end
    if (acc) exp_q.push_back({in_last, ref_pix(in_pix_t, in_pix_t1, in_mask, in_mode)});
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    hs_cnt = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pix", out_pix, 0);
    check("rst_out_last", out_last, 0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) cycle();
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", out_valid, 0);
    check("beat_cnt_model", beat_cnt, hs_cnt);
  endtask

  task automatic lat_check(input string tag, input logic [PW-1:0] t, input logic [PW-1:0] t1,
                           input logic [MW-1:0] m, input logic [1:0] mode, input logic [PW-1:0] exp_pix);
    out_ready = 1'b1;
    drive(1'b1, t, t1, m, mode, 1'b1);
    cycle();
    check({tag, "_accepted"}, last_acc, 1);
    drive_rand(1'b0);
    check({tag, "_lat1_valid"}, out_valid, 0);
    cycle();
    check({tag, "_lat2_valid"}, out_valid, 1);
    check({tag, "_pix"}, out_pix, exp_pix);
    check({tag, "_last"}, out_last, 1);
    cycle();
  endtask

  logic [PW-1:0] bt  [10];
  logic [PW-1:0] bt1 [10];
  logic [MW-1:0] bm  [10];
  logic [1:0]    bmd [10];

  initial begin
    int idx;
    int acc_n;
    int errs;
    int mlist[6];
    mlist = '{0, 1, 127, 128, 254, 255};

    do_reset();

    // Directed blends: all channels carry the same sample so the whole pixel is known.
    lat_check("blend_m255", {CH{8'd200}}, {CH{8'd10}}, 8'd255, MODE_BLEND, {CH{8'd200}});
    lat_check("blend_m0",   {CH{8'd200}}, {CH{8'd10}}, 8'd0,   MODE_BLEND, {CH{8'd10}});
    lat_check("blend_m128", {CH{8'd255}}, {CH{8'd0}},  8'd128, MODE_BLEND, {CH{8'd128}});
    lat_check("blend_m1",   {CH{8'd0}},   {CH{8'd255}}, 8'd1,  MODE_BLEND, {CH{8'd254}});

    // Modes on a three-channel pixel; mask is arbitrary.
    lat_check("pass_t",  {8'd30, 8'd20, 8'd10}, {8'd30, 8'd5, 8'd200}, MW'($urandom), MODE_PASS_T,
              {8'd30, 8'd20, 8'd10});
    lat_check("pass_t1", {8'd30, 8'd20, 8'd10}, {8'd30, 8'd5, 8'd200}, MW'($urandom), MODE_PASS_T1,
              {8'd30, 8'd5, 8'd200});
    lat_check("absdiff", {8'd30, 8'd20, 8'd10}, {8'd30, 8'd5, 8'd200}, MW'($urandom), MODE_ABSDIFF,
              {8'd0, 8'd15, 8'd190});
    drain();

    // Divider against exact rounding over every legal sum.
    errs = 0;
    for (int s = 0; s <= MAXD * MAXM; s++) begin
      div_s = (DW + MW)'(s);
      #1;
      if (div_q !== DW'((2 * s + MAXM) / (2 * MAXM))) errs++;
    end
    check("div_exhaustive_errs", errs, 0);

    // Back-to-back blend stream with boundary masks and random samples.
    out_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      drive(1'b1, PW'({$urandom, $urandom}), PW'({$urandom, $urandom}),
            (i % 2 == 0) ? MW'(mlist[i % 6]) : MW'($urandom), MODE_BLEND, 1'($urandom_range(0, 1)));
      cycle();
    end
    drain();

    // Backpressure: 10 beats with out_ready low in cycles 3..7.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bt[i]  = PW'({$urandom, $urandom});
      bt1[i] = PW'({$urandom, $urandom});
      bm[i]  = MW'($urandom);
      bmd[i] = 2'($urandom_range(0, 3));
    end
    stall_cycles = 0;
    idx = 0;
    for (int c = 0; c < 100 && !(idx == 10 && exp_q.size() == 0 && !out_valid); c++) begin
      out_ready = !(c >= 3 && c <= 7);
      if (idx < 10) drive(1'b1, bt[idx], bt1[idx], bm[idx], bmd[idx], idx == 9);
      else in_valid = 1'b0;
      cycle();
      if (last_acc) idx++;
    end
    check("bp_all_accepted", idx, 10);
    check("bp_stall_cycles", stall_cycles, 5);
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_beat_cnt", beat_cnt, 10);

    // Random valid/ready toggling over 10k accepted beats.
    do_reset();
    acc_n = 0;
    for (int c = 0; c < 60000 && acc_n < 10000; c++) begin
      drive_rand($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_acc) acc_n++;
    end
    check("rand_accepted", acc_n, 10000);
    drain();
    check("rand_beat_cnt", beat_cnt, 10000);

    // Reset with two beats in flight, then resume.
    out_ready = 1'b1;
    drive_rand(1'b1);
    cycle();
    drive_rand(1'b1);
    cycle();
    check("midrst_inflight", out_valid, 1);
    do_reset();
    check("midrst_idle_next", out_valid, 0);
    for (int i = 0; i < 20; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    drain();
    check("midrst_beat_cnt", beat_cnt, 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/neural_blend_pipe.md
# neural_blend_pipe

Streaming, parametrised successor to the single-pixel alpha-blend core in the neural datapath. Blends two multi-channel pixel streams under a per-beat mask with exact rounded division by the mask full-scale. Also supports per-beat pass-through and absolute-difference modes. Two-stage pipeline with valid/ready handshakes on both sides; sits between the frame-buffer readers and the output formatter.

## Interface
- DATA_W, 8, bits per channel sample
- CH, 3, channels per beat (packed, channel 0 in LSBs)
- MASK_W, 8, mask width; full-scale MAXM = 2^MASK_W-1
- CNT_W, 32, width of beat counter

- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous and active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_pix_t  in  CH*DATA_W  foreground pixel
- in_pix_t1  in  CH*DATA_W  background pixel
- in_mask  in  MASK_W  blend weight for in_pix_t (shared by all channels)
- in_mode  in  2  0 BLEND, 1 PASS_T, 2 PASS_T1, 3 ABSDIFF
- in_last  in  1  end-of-line marker, carried with beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_pix  out  CH*DATA_W  result
- out_last  out  1  in_last of the same beat
- beat_cnt  out  CNT_W  count of output handshakes since reset, wraps at 2^CNT_W

## Operation
- Per channel c, with t = in_pix_t[c], t1 = in_pix_t1[c], m = in_mask:
  - BLEND: s = t*m + t1*(MAXM-m), width DATA_W+MASK_W, no overflow (max = MAXD*MAXM). Result = nearest integer to s/MAXM. MAXM is odd, so there are no ties. Result ≤ 2^DATA_W-1, so no saturation.
  - PASS_T: result = t. PASS_T1: result = t1. Mask ignored.
  - ABSDIFF: result = |t - t1|. Mask ignored.
- Division: r = s + 2^(MASK_W-1); q = (r + (r >> MASK_W)) >> MASK_W. This must equal the exact rounded quotient for every legal s. The bench checks this exhaustively for the default widths.
- Stage 1 registers the products/sum (or selected/diff value) plus mode and last. Stage 2 registers the divided/selected result.
- Pipeline enable en = !out_valid | out_ready. Both stages advance only when en=1, and in_ready = en. Bubbles propagate as valid=0.
- beat_cnt increments on every out_valid & out_ready.

## Timing
- Reset (rst_n=0 at a clk edge): out_valid=0, out_pix=0, out_last=0, beat_cnt=0, and all stage valids cleared. in_ready reads 1 in the first cycle after reset.
- Reset asserted mid-stream discards all in-flight beats. No output handshake occurs in the reset cycle.
- Latency: a beat accepted at edge k appears on out_valid after edge k+2 when en stays 1. Throughput is 1 beat/cycle.
- Stall: with out_valid=1 and out_ready=0, en=0, so out_pix, out_last and both stages hold and in_ready=0. Up to 2 beats are buffered, and none are lost or duplicated.
- Simultaneous out handshake and new input: both complete in the same cycle with no bubble.
- in_ready depends combinationally on out_ready (documented path). There is no combinational in_valid→out_valid path.
- Data inputs are ignored when in_valid=0, and outputs are don't-care in value when out_valid=0, except immediately after reset (zero).

## Structure
- Shared package neural_pkg:
  - mode enum (BLEND, PASS_T, PASS_T1, ABSDIFF)
  - localparams MAXM and MAXD derived from the widths
  - per-channel slice helper
- Sub-module neural_div_maxm: the single-channel, purely combinational rounded divide-by-MAXM of a DATA_W+MASK_W input. Instantiated CH times in stage 2.
- Top level holds the two stage registers, the enable logic and beat_cnt.

## Test plan
- BLEND, single channel values t=200, t1=10: m=255 → 200; m=0 → 10; t=255, t1=0, m=128 → 128; t=0, t1=255, m=1 → 254. Each appears exactly 2 cycles after acceptance.
- Exhaustive BLEND sweep of t, t1, m (8-bit, channel 0) compared against round(s/255). Zero mismatches.
- Modes on CH=3 pixel t={10,20,30}, t1={200,5,30}: PASS_T → {10,20,30}; PASS_T1 → {200,5,30}; ABSDIFF → {190,15,0}.
- Backpressure: 10 back-to-back beats with out_ready low for cycles 3–7. in_ready drops once 2 beats are held, all 10 beats emerge in order with correct out_last, and beat_cnt=10.
- Random valid/ready toggling over 10k beats against a scoreboard. No loss or duplication, and out_last is aligned.
- rst_n pulsed low for one cycle with 2 beats in flight. Next cycle: out_valid=0, beat_cnt=0, in_ready=1. Beats accepted afterwards produce correct results.
